// File: rtl/ftdi_bus_sched_if.sv
// ---------------------------------------------------------------------------
// ftdi_bus_sched_if
// Groups the FT245 handshake flags, the local buffer status flags and the
// strobes produced by ftdi_bus_sched.
//
// Signals
//   iRxF_n      FT245 RXF#, low = host has a byte available
//   iTxE_n      FT245 TXE#, low = FTDI can accept a byte
//   iRxBufFull  local receive buffer full
//   iTxBufEmpty local transmit buffer empty
//   oRx_n       FT245 RD# strobe, active low
//   oTx_n       FT245 WR strobe, active low
//   oSiwu       FT245 SIWU#, active low
//   oBusOe      FPGA drives the 8-bit FIFO data bus
//   oRxWrEn     capture bus byte into local RX buffer (1 cycle)
//   oTxRdEn     pop local TX buffer (1 cycle, data valid next cycle)
//   oBusy       scheduler not idle
//   oDir        direction of current/last transfer (0 read, 1 write)
//
// Modports
//   master  the scheduler side (drives the o* strobes)
//   slave   the FTDI / buffer side (drives the i* flags)
// ---------------------------------------------------------------------------
interface ftdi_bus_sched_if;
    logic iRxF_n;
    logic iTxE_n;
    logic iRxBufFull;
    logic iTxBufEmpty;
    logic oRx_n;
    logic oTx_n;
    logic oSiwu;
    logic oBusOe;
    logic oRxWrEn;
    logic oTxRdEn;
    logic oBusy;
    logic oDir;

    modport master (
        input  iRxF_n, iTxE_n, iRxBufFull, iTxBufEmpty,
        output oRx_n, oTx_n, oSiwu, oBusOe, oRxWrEn, oTxRdEn, oBusy, oDir
    );

    modport slave (
        output iRxF_n, iTxE_n, iRxBufFull, iTxBufEmpty,
        input  oRx_n, oTx_n, oSiwu, oBusOe, oRxWrEn, oTxRdEn, oBusy, oDir
    );
endinterface

// File: rtl/ftdi_bus_sched.sv
// ---------------------------------------------------------------------------
// ftdi_bus_sched
// Arbitrates the half-duplex FT245 FIFO bus between host-to-FPGA reads and
// FPGA-to-host writes, generating RD#/WR strobes, bus output enable, local
// buffer strobes and an optional SIWU# flush pulse.
//
// Ports
//   iClk    system clock, all logic on rising edge
//   iRst_n  asynchronous active-low reset
//   bus     ftdi_bus_sched_if.master (flags in, strobes out)
//
// Parameters
//   pRdPulseCycles  RD# low cycles per read         (1..15)
//   pWrPulseCycles  WR low cycles per write         (1..15)
//   pTurnCycles     turnaround cycles write->read   (1..7)
//   pBurstMax       same-direction burst limit when both pending (1..15)
//   pFlushIdle      idle cycles after a write before SIWU# pulse (2..255)
//
// Build option
//   FTDI_SIWU_FLUSH_EN  when defined, a SIWU# pulse flushes the FTDI after
//                       pFlushIdle idle cycles following a write; otherwise
//                       oSiwu is tied high.
//
// All outputs come straight from flops loaded with next-state decodes.
// ---------------------------------------------------------------------------
module ftdi_bus_sched #(
    parameter int pRdPulseCycles = 3,
    parameter int pWrPulseCycles = 3,
    parameter int pTurnCycles    = 1,
    parameter int pBurstMax      = 4,
    parameter int pFlushIdle     = 16
) (
    input  logic               iClk,
    input  logic               iRst_n,
    ftdi_bus_sched_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_LOW,
        RD_REC,
        TURN,
        WR_SETUP,
        WR_LOW,
        WR_HOLD
`ifdef FTDI_SIWU_FLUSH_EN
        , FLUSH
`endif
    } state_t;

    localparam logic [3:0] cRdLast   = 4'(pRdPulseCycles - 1);
    localparam logic [3:0] cWrLast   = 4'(pWrPulseCycles - 1);
    localparam logic [3:0] cTurnLast = 4'(pTurnCycles - 1);
    localparam logic [3:0] cBurstMax = 4'(pBurstMax);

    if (pRdPulseCycles < 1 || pRdPulseCycles > 15 ||
        pWrPulseCycles < 1 || pWrPulseCycles > 15 ||
        pTurnCycles < 1 || pTurnCycles > 7 ||
        pBurstMax < 1 || pBurstMax > 15 ||
        pFlushIdle < 2 || pFlushIdle > 255) begin : gBadParam
        $error("ftdi_bus_sched: parameter out of range");
    end

    function automatic logic [3:0] satInc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    state_t     state, stateNext;
    logic [3:0] cnt, cntNext;
    logic [3:0] burstCnt, burstNext;
    logic       dirQ, dirNext;
    logic       rxReq, txReq;
    logic       grantRd, grantWr;
    logic       rxWrEnNext, txRdEnNext;
    logic       rxStrobeN, txStrobeN, busOeQ, rxWrEnQ, txRdEnQ, busyQ;

`ifdef FTDI_SIWU_FLUSH_EN
    localparam logic [7:0] cFlushLast = 8'(pFlushIdle - 1);
    logic       flushArmed, armNext;
    logic [7:0] idleCnt, idleNext;
    logic       siwuQ;
`endif

    // Request terms are only consulted while IDLE, so flag changes during
    // a transfer never alter it.
    assign rxReq = !bus.iRxF_n && !bus.iRxBufFull;
    assign txReq = !bus.iTxE_n && !bus.iTxBufEmpty;

    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        burstNext  = burstCnt;
        dirNext    = dirQ;
        txRdEnNext = 1'b0;
        grantRd    = 1'b0;
        grantWr    = 1'b0;
`ifdef FTDI_SIWU_FLUSH_EN
        armNext    = flushArmed;
        idleNext   = idleCnt;
`endif

        // Both pending: stay in the current direction until the burst
        // limit, then hand over. dirQ=0 after reset gives rx the tie.
        if (state == IDLE) begin
            if (rxReq && txReq) begin
                if (burstCnt < cBurstMax) begin
                    grantRd = !dirQ;
                    grantWr = dirQ;
                end else begin
                    grantRd = dirQ;
                    grantWr = !dirQ;
                end
            end else begin
                grantRd = rxReq;
                grantWr = txReq;
            end
        end

        case (state)
            IDLE: begin
                if (grantRd) begin
                    burstNext = dirQ ? 4'd1 : satInc(burstCnt);
                    dirNext   = 1'b0;
                    // The FTDI needs the bus released before it drives it.
                    if (dirQ) begin
                        stateNext = TURN;
                        cntNext   = cTurnLast;
                    end else begin
                        stateNext = RD_LOW;
                        cntNext   = cRdLast;
                    end
                end else if (grantWr) begin
                    burstNext  = dirQ ? satInc(burstCnt) : 4'd1;
                    dirNext    = 1'b1;
                    stateNext  = WR_SETUP;
                    cntNext    = 4'd1;
                    txRdEnNext = 1'b1;
`ifdef FTDI_SIWU_FLUSH_EN
                    armNext    = 1'b1;
`endif
                end
`ifdef FTDI_SIWU_FLUSH_EN
                if (grantRd || grantWr) begin
                    idleNext = 8'd0;
                end else if (flushArmed) begin
                    if (idleCnt == cFlushLast) begin
                        stateNext = FLUSH;
                        idleNext  = 8'd0;
                    end else begin
                        idleNext = idleCnt + 8'd1;
                    end
                end
`endif
            end
            TURN: begin
                if (cnt == 4'd0) begin
                    stateNext = RD_LOW;
                    cntNext   = cRdLast;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end
            RD_LOW: begin
                if (cnt == 4'd0) stateNext = RD_REC;
                else             cntNext   = cnt - 4'd1;
            end
            RD_REC: stateNext = IDLE;
            WR_SETUP: begin
                if (cnt == 4'd0) begin
                    stateNext = WR_LOW;
                    cntNext   = cWrLast;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end
            WR_LOW: begin
                if (cnt == 4'd0) stateNext = WR_HOLD;
                else             cntNext   = cnt - 4'd1;
            end
            WR_HOLD: stateNext = IDLE;
`ifdef FTDI_SIWU_FLUSH_EN
            FLUSH: begin
                stateNext = IDLE;
                armNext   = 1'b0;
            end
`endif
            default: stateNext = IDLE;
        endcase

        // Capture strobe lands in the final RD# low cycle.
        rxWrEnNext = (stateNext == RD_LOW) && (cntNext == 4'd0);
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            burstCnt  <= 4'd0;
            dirQ      <= 1'b0;
            rxStrobeN <= 1'b1;
            txStrobeN <= 1'b1;
            busOeQ    <= 1'b0;
            rxWrEnQ   <= 1'b0;
            txRdEnQ   <= 1'b0;
            busyQ     <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            burstCnt  <= burstNext;
            dirQ      <= dirNext;
            rxStrobeN <= (stateNext != RD_LOW);
            txStrobeN <= (stateNext != WR_LOW);
            busOeQ    <= (stateNext == WR_SETUP) || (stateNext == WR_LOW) ||
                         (stateNext == WR_HOLD);
            rxWrEnQ   <= rxWrEnNext;
            txRdEnQ   <= txRdEnNext;
            busyQ     <= (stateNext != IDLE);
        end
    end

`ifdef FTDI_SIWU_FLUSH_EN
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            flushArmed <= 1'b0;
            idleCnt    <= 8'd0;
            siwuQ      <= 1'b1;
        end else begin
            flushArmed <= armNext;
            idleCnt    <= idleNext;
            siwuQ      <= (stateNext != FLUSH);
        end
    end
    assign bus.oSiwu = siwuQ;
`else
    assign bus.oSiwu = 1'b1;
`endif

    assign bus.oRx_n   = rxStrobeN;
    assign bus.oTx_n   = txStrobeN;
    assign bus.oBusOe  = busOeQ;
    assign bus.oRxWrEn = rxWrEnQ;
    assign bus.oTxRdEn = txRdEnQ;
    assign bus.oBusy   = busyQ;
    assign bus.oDir    = dirQ;

endmodule

// File: tb/tb_ftdi_bus_sched.sv
// ---------------------------------------------------------------------------
// tb_ftdi_bus_sched
// Directed bench for ftdi_bus_sched with default parameters. Inputs change
// and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ftdi_bus_sched;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ftdi_bus_sched_if bus();

    ftdi_bus_sched dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    int nChecks = 0;
    int nPass   = 0;

    logic [7:0] busData = 8'hA5;
    logic [7:0] captured;
    always @(posedge clk) if (bus.oRxWrEn) captured <= busData;

    logic lRx[0:63], lTx[0:63], lOe[0:63], lBusy[0:63];
    logic lWrEn[0:63], lRdEn[0:63], lSiwu[0:63];

    task automatic grab(input int i);
        lRx[i]   = bus.oRx_n;
        lTx[i]   = bus.oTx_n;
        lOe[i]   = bus.oBusOe;
        lBusy[i] = bus.oBusy;
        lWrEn[i] = bus.oRxWrEn;
        lRdEn[i] = bus.oTxRdEn;
        lSiwu[i] = bus.oSiwu;
    endtask

    task automatic setReq(input logic rxF_n, input logic rxFull,
                          input logic txE_n, input logic txEmpty);
        bus.iRxF_n      = rxF_n;
        bus.iRxBufFull  = rxFull;
        bus.iTxE_n      = txE_n;
        bus.iTxBufEmpty = txEmpty;
    endtask

    task automatic doReset;
        @(negedge clk);
        setReq(1'b1, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        setReq(1'b1, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        nChecks++; if (bus.oRx_n !== 1'b1) $display("FAIL rst_rx_n got %b want 1", bus.oRx_n); else nPass++;
        nChecks++; if (bus.oTx_n !== 1'b1) $display("FAIL rst_tx_n got %b want 1", bus.oTx_n); else nPass++;
        nChecks++; if (bus.oSiwu !== 1'b1) $display("FAIL rst_siwu got %b want 1", bus.oSiwu); else nPass++;
        nChecks++; if (bus.oBusOe !== 1'b0) $display("FAIL rst_busoe got %b want 0", bus.oBusOe); else nPass++;
        nChecks++; if (bus.oRxWrEn !== 1'b0) $display("FAIL rst_rxwren got %b want 0", bus.oRxWrEn); else nPass++;
        nChecks++; if (bus.oTxRdEn !== 1'b0) $display("FAIL rst_txrden got %b want 0", bus.oTxRdEn); else nPass++;
        nChecks++; if (bus.oBusy !== 1'b0) $display("FAIL rst_busy got %b want 0", bus.oBusy); else nPass++;
        nChecks++; if (bus.oDir !== 1'b0) $display("FAIL rst_dir got %b want 0", bus.oDir); else nPass++;
        rst_n = 1'b1;
    endtask

    task automatic test_single_read;
        int lowCnt = 0, wrEnCnt = 0, wrEnIdx = -1, oeCnt = 0;
        doReset();
        setReq(1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk); grab(0);
        setReq(1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i < 10; i++) begin @(negedge clk); grab(i); end
        for (int i = 0; i < 10; i++) begin
            if (!lRx[i]) lowCnt++;
            if (lWrEn[i]) begin wrEnCnt++; wrEnIdx = i; end
            if (lOe[i]) oeCnt++;
        end
        nChecks++; if (lRx[0] !== 1'b0) $display("FAIL rd_first_low got %b want 0", lRx[0]); else nPass++;
        nChecks++; if (lowCnt != 3) $display("FAIL rd_low_cycles got %0d want 3", lowCnt); else nPass++;
        nChecks++; if (wrEnCnt != 1) $display("FAIL rd_wren_count got %0d want 1", wrEnCnt); else nPass++;
        nChecks++; if (wrEnIdx != 2) $display("FAIL rd_wren_cycle got %0d want 2", wrEnIdx); else nPass++;
        nChecks++; if (captured !== 8'hA5) $display("FAIL rd_capture got %h want a5", captured); else nPass++;
        nChecks++; if (lBusy[3] !== 1'b1) $display("FAIL rd_busy_last got %b want 1", lBusy[3]); else nPass++;
        nChecks++; if (lBusy[4] !== 1'b0) $display("FAIL rd_idle_at5 got %b want 0", lBusy[4]); else nPass++;
        nChecks++; if (oeCnt != 0) $display("FAIL rd_busoe got %0d want 0", oeCnt); else nPass++;
        nChecks++; if (bus.oDir !== 1'b0) $display("FAIL rd_dir got %b want 0", bus.oDir); else nPass++;
    endtask

    task automatic test_rx_full;
        int rxLow = 0, rdEnCnt = 0, txLow = 0, busyErr = 0, oeErr = 0;
        doReset();
        setReq(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 28; i++) begin @(negedge clk); grab(i); end
        for (int i = 0; i < 28; i++) begin
            if (!lRx[i]) rxLow++;
            if (lRdEn[i]) rdEnCnt++;
            if (!lTx[i]) txLow++;
            if (lBusy[i] !== ((i % 7) != 6)) busyErr++;
            if (lOe[i] !== ((i % 7) != 6)) oeErr++;
        end
        nChecks++; if (rxLow != 0) $display("FAIL full_rx_pulses got %0d want 0", rxLow); else nPass++;
        nChecks++; if (rdEnCnt != 4) $display("FAIL full_txrden got %0d want 4", rdEnCnt); else nPass++;
        nChecks++; if (txLow != 12) $display("FAIL full_tx_low got %0d want 12", txLow); else nPass++;
        nChecks++; if (busyErr != 0) $display("FAIL full_7cycle_period got %0d bad want 0", busyErr); else nPass++;
        nChecks++; if (oeErr != 0) $display("FAIL full_busoe_window got %0d bad want 0", oeErr); else nPass++;
        nChecks++; if (bus.oDir !== 1'b1) $display("FAIL full_dir got %b want 1", bus.oDir); else nPass++;
    endtask

    task automatic test_burst;
        logic [8:0] seq = 9'd0;
        int k = 0, lastOe = -1, firstRd = -1, gapBusy = 0, gapOe = 0, clash = 0;
        doReset();
        setReq(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 56; i++) begin @(negedge clk); grab(i); end
        for (int i = 0; i < 56; i++) begin
            if (lWrEn[i] || lRdEn[i]) begin
                if (k < 9) seq[k] = lRdEn[i];
                k++;
            end
            if (lOe[i]) lastOe = i;
            if (lOe[i] && !lRx[i]) clash++;
        end
        for (int i = 55; i > lastOe; i--) if (!lRx[i]) firstRd = i;
        for (int i = lastOe + 1; i < firstRd; i++) begin
            if (lBusy[i]) gapBusy++;
            if (lOe[i]) gapOe++;
        end
        nChecks++; if (k < 9) $display("FAIL burst_xfer_count got %0d want >=9", k); else nPass++;
        nChecks++; if (seq !== 9'h0F0) $display("FAIL burst_sequence got %b want 011110000 (msb=9th, 1=W)", seq); else nPass++;
        nChecks++; if (firstRd - lastOe != 3) $display("FAIL burst_turn_gap got %0d want 3", firstRd - lastOe); else nPass++;
        nChecks++; if (gapBusy != 1) $display("FAIL burst_turn_cycles got %0d want 1", gapBusy); else nPass++;
        nChecks++; if (gapOe != 0) $display("FAIL burst_turn_busoe got %0d want 0", gapOe); else nPass++;
        nChecks++; if (clash != 0) $display("FAIL burst_oe_rd_clash got %0d want 0", clash); else nPass++;
    endtask

    task automatic test_reset_mid_write;
        int waited = 0, rdEnCnt = 0, busyCnt = 0;
        doReset();
        setReq(1'b1, 1'b0, 1'b0, 1'b0);
        do begin @(negedge clk); waited++; end while (bus.oTx_n !== 1'b0 && waited < 20);
        nChecks++; if (bus.oTx_n !== 1'b0) $display("FAIL rstw_reach_wrlow got %b want 0", bus.oTx_n); else nPass++;
        rst_n = 1'b0;
        setReq(1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        nChecks++; if (bus.oTx_n !== 1'b1) $display("FAIL rstw_tx_n got %b want 1", bus.oTx_n); else nPass++;
        nChecks++; if (bus.oBusOe !== 1'b0) $display("FAIL rstw_busoe got %b want 0", bus.oBusOe); else nPass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.oTxRdEn) rdEnCnt++;
            if (bus.oBusy) busyCnt++;
        end
        nChecks++; if (rdEnCnt != 0) $display("FAIL rstw_no_txrden got %0d want 0", rdEnCnt); else nPass++;
        nChecks++; if (busyCnt != 0) $display("FAIL rstw_stays_idle got %0d want 0", busyCnt); else nPass++;
        setReq(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        setReq(1'b1, 1'b0, 1'b1, 1'b1);
        nChecks++; if (bus.oTxRdEn !== 1'b1) $display("FAIL rstw_first_grant got %b want 1", bus.oTxRdEn); else nPass++;
    endtask

    task automatic test_flush;
        int lowCnt = 0, lowIdx = -1, lateBusy = 0;
        doReset();
        setReq(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); grab(0);
        setReq(1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i < 30; i++) begin @(negedge clk); grab(i); end
        for (int i = 0; i < 30; i++) begin
            if (!lSiwu[i]) begin lowCnt++; lowIdx = i; end
            if (i >= 6 && lBusy[i]) lateBusy++;
        end
`ifdef FTDI_SIWU_FLUSH_EN
        nChecks++; if (lowCnt != 1) $display("FAIL flush_pulse_count got %0d want 1", lowCnt); else nPass++;
        nChecks++; if (lowIdx != 22) $display("FAIL flush_pulse_cycle got %0d want 22", lowIdx); else nPass++;
        nChecks++; if (lateBusy != 1) $display("FAIL flush_busy_cycles got %0d want 1", lateBusy); else nPass++;
`else
        nChecks++; if (lowCnt != 0) $display("FAIL noflush_siwu got %0d low want 0", lowCnt); else nPass++;
        nChecks++; if (lateBusy != 0) $display("FAIL noflush_busy got %0d want 0", lateBusy); else nPass++;
`endif
        nChecks++; if (lBusy[6] !== 1'b0) $display("FAIL flush_idle_after_write got %b want 0", lBusy[6]); else nPass++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_rx_full();
        test_burst();
        test_reset_mid_write();
        test_flush();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/ftdi_bus_sched.md
FTDI_BUS_SCHED -- requirements
Module: ftdi_bus_sched

Interface
REQ-001 Parameter pRdPulseCycles, default 3: cycles oRx_n is held low per read (1..15).
REQ-002 Parameter pWrPulseCycles, default 3: cycles oTx_n is held low per write (1..15).
REQ-003 Parameter pTurnCycles, default 1: bus-turnaround cycles inserted on every write-to-read direction change (1..7).
REQ-004 Parameter pBurstMax, default 4: maximum consecutive same-direction transfers while the other direction is pending (1..15).
REQ-005 Parameter pFlushIdle, default 16: idle cycles after the last write before the SIWU flush pulse (2..255).
REQ-006 iClk  in  1  single system clock; all logic on its rising edge.
REQ-007 iRst_n  in  1  asynchronous, active-low reset.
REQ-008 iRxF_n  in  1  FT245 RXF#; low means the host has a byte available.
REQ-009 iTxE_n  in  1  FT245 TXE#; low means the FTDI can accept a byte.
REQ-010 iRxBufFull  in  1  local receive buffer full.
REQ-011 iTxBufEmpty  in  1  local transmit buffer empty.
REQ-012 oRx_n  out  1  FT245 RD# strobe, active low.
REQ-013 oTx_n  out  1  FT245 WR strobe, active low.
REQ-014 oSiwu  out  1  FT245 SIWU#, active low.
REQ-015 oBusOe  out  1  enables FPGA drive of the 8-bit FIFO data bus.
REQ-016 oRxWrEn  out  1  one-cycle strobe: capture the bus byte into the local RX buffer.
REQ-017 oTxRdEn  out  1  one-cycle strobe: pop the local TX buffer (data valid the following cycle).
REQ-018 oBusy  out  1  high in every state except IDLE.
REQ-019 oDir  out  1  direction of the current or last transfer: 0 = read, 1 = write.

Function
REQ-020 All outputs are registered; FSM states: IDLE, RD_LOW, RD_REC, TURN, WR_SETUP, WR_LOW, WR_HOLD, FLUSH.
REQ-021 IDLE request terms: rx_req = !iRxF_n & !iRxBufFull; tx_req = !iTxE_n & !iTxBufEmpty; both are evaluated only in IDLE.
REQ-022 Only one request pending: that direction is granted; both pending: the current direction continues while burst count < pBurstMax, otherwise the other direction is granted; after reset, rx has priority on a tie.
REQ-023 Burst count increments per completed transfer, resets to 1 on a direction change, saturates at 15, and is ignored when the other direction is idle.
REQ-024 Read: IDLE -> RD_LOW (oRx_n=0 for pRdPulseCycles) -> RD_REC (1 cycle, oRx_n=1) -> IDLE; oRxWrEn pulses in the last RD_LOW cycle.
REQ-025 Read grant following a write enters TURN for pTurnCycles (oBusOe=0, both strobes high), then RD_LOW.
REQ-026 Write: IDLE -> WR_SETUP (2 cycles; oTxRdEn in the first; oBusOe=1 from the first) -> WR_LOW (oTx_n=0 for pWrPulseCycles) -> WR_HOLD (1 cycle, oTx_n=1, oBusOe=1) -> IDLE with oBusOe=0.
REQ-027 Default timing, grant decided in IDLE cycle N: read occupies N+1..N+4, IDLE again at N+5; write occupies N+1..N+6, IDLE again at N+7.
REQ-028 oBusOe and oRx_n=0 are never asserted in the same cycle.
REQ-029 iRxF_n or iTxE_n deasserting mid-transfer has no effect; the transfer completes.
REQ-030 iRxBufFull or iTxBufEmpty changing mid-transfer has no effect; exactly one strobe is issued per transfer.

Reset
REQ-031 iRst_n low immediately forces IDLE and sets oRx_n=1, oTx_n=1, oSiwu=1, oBusOe=0, oRxWrEn=0, oTxRdEn=0, oBusy=0, oDir=0, burst count=0, priority=rx, flush armed=0.
REQ-032 Reset mid-transfer aborts the transfer with no further strobes; the first grant is decided in the first IDLE cycle after iRst_n rises.

Configuration
REQ-033 Macro FTDI_SIWU_FLUSH_EN defined: after any write, flush is armed; pFlushIdle consecutive IDLE cycles with no grant -> FLUSH (1 cycle, oSiwu=0) -> IDLE, then disarm.
REQ-034 A grant during the idle count restarts the count; a write re-arms the flush.
REQ-035 Macro FTDI_SIWU_FLUSH_EN undefined: the FLUSH state and idle counter are absent and oSiwu is constant 1.

Verification
REQ-036 Reset: iRst_n=0 asserted during WR_LOW -> same cycle oTx_n=1, oBusOe=0; no oTxRdEn after release until tx_req.
REQ-037 Single read: iRxF_n=0 for 1 cycle, bus=0xA5 -> oRx_n low exactly 3 cycles, one oRxWrEn in the 3rd, captured byte 0xA5, IDLE after 5 cycles.
REQ-038 Both pending continuously, pBurstMax=4 -> sequence R,R,R,R,W,W,W,W,R; exactly 1 TURN cycle with oBusOe=0 before the 9th transfer.
REQ-039 iRxF_n=0 with iRxBufFull=1, tx_req=1 -> zero oRx_n pulses; writes only, each lasting 7 cycles IDLE-to-IDLE.
REQ-040 FTDI_SIWU_FLUSH_EN defined: 1 write then idle -> oSiwu low for 1 cycle exactly 16 cycles after return to IDLE; undefined: oSiwu stays 1.
